// File: rtl/tx_fifo.sv
// tx_fifo: transmit buffer between the outgoing AHIR pipe and the MAC's AXI-Stream TX input.
// Pipe words {tlast, tdata, tkeep} are queued in a circular buffer and replayed as AXI-S beats.
// Frames are sent store-and-forward: a frame starts only after its tlast word is buffered.
// When the buffer fills with no complete frame, the block falls back to cut-through.
// If a cut-through frame then runs dry, the sticky underrun flag is set.
module tx_fifo #(
    parameter int N     = 32,
    parameter int S     = 4,
    parameter int D     = 37,
    parameter int DEPTH = 128,
    parameter int D_S   = 7
) (
    input  logic         clk,
    input  logic         reset,
    output logic         tx_axis_resetn,
    input  logic [D-1:0] pipe_read_data,
    output logic         pipe_read_req,
    input  logic         pipe_read_ack,
    output logic [N-1:0] tx_axis_tdata,
    output logic [S-1:0] tx_axis_tkeep,
    output logic         tx_axis_tvalid,
    output logic         tx_axis_tlast,
    input  logic         tx_axis_tready,
    output logic [15:0]  frames_sent,
    output logic         underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [D_S:0] DEPTH_C = (D_S+1)'(DEPTH);
    localparam logic [D_S:0] ONE_C   = (D_S+1)'(1);

    logic [D-1:0]   fifo_mem [DEPTH];

    logic [D_S-1:0] front_reg;
    logic [D_S-1:0] rear_reg;
    logic [D_S:0]   count_reg;
    logic [D_S:0]   count_next;
    logic [D_S:0]   frames_ready_reg;
    logic [D_S:0]   frames_ready_next;
    logic [1:0]     state_reg;
    logic [1:0]     state_next;
    logic [D-1:0]   out_word_reg;
    logic           tvalid_reg;
    logic           tvalid_next;
    logic           req_reg;
    logic           resetn_reg;
    logic [15:0]    frames_sent_reg;
    logic           underrun_reg;

    logic           push;
    logic           load;
    logic           beat_done;
    logic           frame_done;
    logic           set_underrun;
    logic           in_last;
    logic [S-1:0]   in_keep;
    logic [S-1:0]   wr_keep;
    logic [D-1:0]   wr_word;

    assign push      = req_reg & pipe_read_ack;
    assign beat_done = tvalid_reg & tx_axis_tready;
    assign in_last   = pipe_read_data[D-1];
    assign in_keep   = pipe_read_data[S-1:0];

    // Sanitise byte enables: inner words are always full, a last word keeps at least one byte.
    always_comb begin
        wr_keep = in_keep;
        if (!in_last) begin
            wr_keep = '1;
        end else if (in_keep == '0) begin
            wr_keep = (S)'(1);
        end
    end

    assign wr_word = {in_last, pipe_read_data[D-2:S], wr_keep};

    // Output sequencing: decide when to pop the head word into the output register.
    always_comb begin
        load         = 1'b0;
        frame_done   = 1'b0;
        set_underrun = 1'b0;
        state_next   = state_reg;
        tvalid_next  = tvalid_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frames_ready_reg != '0 || count_reg == DEPTH_C) begin
                    load        = 1'b1;
                    tvalid_next = 1'b1;
                    state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_done) begin
                    if (out_word_reg[D-1]) begin
                        frame_done = 1'b1;
                        // Only frames fully buffered before this edge may follow back-to-back.
                        if (frames_ready_reg > ONE_C) begin
                            load = 1'b1;
                        end else begin
                            tvalid_next = 1'b0;
                            state_next  = ST_IDLE;
                        end
                    end else if (count_reg != '0) begin
                        load = 1'b1;
                    end else begin
                        tvalid_next  = 1'b0;
                        set_underrun = 1'b1;
                        state_next   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_reg != '0) begin
                    load        = 1'b1;
                    tvalid_next = 1'b1;
                    state_next  = ST_SEND;
                end
            end
            default: begin
                tvalid_next = 1'b0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    // Occupancy and complete-frame bookkeeping for simultaneous push/pop.
    always_comb begin
        count_next = count_reg;
        case ({push, load})
            2'b10:   count_next = count_reg + ONE_C;
            2'b01:   count_next = count_reg - ONE_C;
            default: count_next = count_reg;
        endcase
        frames_ready_next = frames_ready_reg;
        case ({push & in_last, frame_done})
            2'b10:   frames_ready_next = frames_ready_reg + ONE_C;
            2'b01:   frames_ready_next = frames_ready_reg - ONE_C;
            default: frames_ready_next = frames_ready_reg;
        endcase
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[rear_reg] <= wr_word;
        end
    end

    // Control state, pointers, output register and status counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            front_reg        <= '0;
            rear_reg         <= '0;
            count_reg        <= '0;
            frames_ready_reg <= '0;
            state_reg        <= ST_IDLE;
            out_word_reg     <= '0;
            tvalid_reg       <= 1'b0;
            req_reg          <= 1'b0;
            resetn_reg       <= 1'b0;
            frames_sent_reg  <= '0;
            underrun_reg     <= 1'b0;
        end else begin
            resetn_reg       <= 1'b1;
            req_reg          <= (count_next < DEPTH_C);
            count_reg        <= count_next;
            frames_ready_reg <= frames_ready_next;
            state_reg        <= state_next;
            tvalid_reg       <= tvalid_next;
            if (push) begin
                rear_reg <= rear_reg + (D_S)'(1);
            end
            if (load) begin
                out_word_reg <= fifo_mem[front_reg];
                front_reg    <= front_reg + (D_S)'(1);
            end
            if (frame_done) begin
                frames_sent_reg <= frames_sent_reg + 16'd1;
            end
            if (set_underrun) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    assign tx_axis_resetn = resetn_reg;
    assign pipe_read_req  = req_reg;
    assign tx_axis_tvalid = tvalid_reg;
    assign tx_axis_tlast  = out_word_reg[D-1];
    assign tx_axis_tdata  = out_word_reg[D-2:S];
    assign tx_axis_tkeep  = out_word_reg[S-1:0];
    assign frames_sent    = frames_sent_reg;
    assign underrun       = underrun_reg;

endmodule
